// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU front-end sequencer: default widths, the
// supported opcode set and the exported FSM state encoding.
package alu_operand_sequencer_pkg;

    localparam int NB_DATA_DEF   = 8;
    localparam int NB_OPCODE_DEF = 6;
    localparam int NB_STATE_DEF  = 3;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    // Encoding is shown on the board LEDs, so the values are fixed.
    typedef enum logic [2:0] {
        S_OP1  = 3'd0,
        S_OP2  = 3'd1,
        S_OPC  = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic is_valid_opcode(input logic [5:0] opc);
        logic ok;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRL, OP_SRA: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_btn_edge_detect.sv
// Rising-edge detector for already-debounced button levels: one flop per bit,
// pulse is high for the single cycle where the level goes 0 -> 1.
module alu_operand_sequencer_btn_edge_detect #(
    parameter int NB = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NB-1:0] level,
    output logic [NB-1:0] pulse
);

    logic [NB-1:0] level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Board front-end for the combinational ALU: loads operand 1, operand 2 and
// opcode from the switches one press at a time, then registers the result.
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int NB_DATA   = NB_DATA_DEF,
    parameter int NB_OPCODE = NB_OPCODE_DEF,
    parameter int NB_STATE  = NB_STATE_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_sw,
    input  logic                 i_btn_load,
    input  logic                 i_btn_abort,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic [NB_DATA-1:0]   o_op_1,
    output logic [NB_DATA-1:0]   o_op_2,
    output logic [NB_OPCODE-1:0] o_opcode,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_valid,
    output logic                 o_err_opcode,
    output logic [NB_STATE-1:0]  o_state
);

    state_t state;
    state_t state_next;

    logic ld;
    logic ab;

    logic [NB_DATA-1:0]   op_1_next;
    logic [NB_DATA-1:0]   op_2_next;
    logic [NB_OPCODE-1:0] opcode_next;
    logic [NB_DATA-1:0]   result_next;
    logic                 valid_next;
    logic                 err_next;

    alu_operand_sequencer_btn_edge_detect #(.NB(1)) u_load_edge (
        .clk   (i_clk),
        .reset (i_reset),
        .level (i_btn_load),
        .pulse (ld)
    );

    alu_operand_sequencer_btn_edge_detect #(.NB(1)) u_abort_edge (
        .clk   (i_clk),
        .reset (i_reset),
        .level (i_btn_abort),
        .pulse (ab)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= S_OP1;
            o_op_1       <= '0;
            o_op_2       <= '0;
            o_opcode     <= '0;
            o_result     <= '0;
            o_valid      <= 1'b0;
            o_err_opcode <= 1'b0;
        end else begin
            state        <= state_next;
            o_op_1       <= op_1_next;
            o_op_2       <= op_2_next;
            o_opcode     <= opcode_next;
            o_result     <= result_next;
            o_valid      <= valid_next;
            o_err_opcode <= err_next;
        end
    end

    always_comb begin
        state_next  = state;
        op_1_next   = o_op_1;
        op_2_next   = o_op_2;
        opcode_next = o_opcode;
        result_next = o_result;
        valid_next  = o_valid;
        err_next    = o_err_opcode;

        // Abort beats a same-cycle load; data registers are left as they are.
        if (ab) begin
            state_next = S_OP1;
            valid_next = 1'b0;
            err_next   = 1'b0;
        end else begin
            case (state)
                S_OP1: begin
                    if (ld) begin
                        op_1_next  = i_sw;
                        state_next = S_OP2;
                    end
                end
                S_OP2: begin
                    if (ld) begin
                        op_2_next  = i_sw;
                        state_next = S_OPC;
                    end
                end
                S_OPC: begin
                    if (ld) begin
                        if (is_valid_opcode(i_sw[NB_OPCODE-1:0])) begin
                            opcode_next = i_sw[NB_OPCODE-1:0];
                            err_next    = 1'b0;
                            state_next  = S_EXEC;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    // The ALU has had a full cycle on the registered operands.
                    result_next = i_alu_result;
                    valid_next  = 1'b1;
                    state_next  = S_DONE;
                end
                S_DONE: begin
                    if (ld) begin
                        op_1_next  = i_sw;
                        valid_next = 1'b0;
                        state_next = S_OP2;
                    end
                end
                default: begin
                    valid_next = 1'b0;
                    state_next = S_OP1;
                end
            endcase
        end
    end

    assign o_state = NB_STATE'(state);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_alu_operand_sequencer;

    logic       clk;
    logic       reset;
    logic [7:0] sw;
    logic       btn_load;
    logic       btn_abort;
    logic [7:0] alu_result;
    logic [7:0] op_1;
    logic [7:0] op_2;
    logic [5:0] opcode;
    logic [7:0] result;
    logic       valid;
    logic       err_opcode;
    logic [2:0] state;

    int compared;
    int mismatched;

    alu_operand_sequencer dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_sw         (sw),
        .i_btn_load   (btn_load),
        .i_btn_abort  (btn_abort),
        .i_alu_result (alu_result),
        .o_op_1       (op_1),
        .o_op_2       (op_2),
        .o_opcode     (opcode),
        .o_result     (result),
        .o_valid      (valid),
        .o_err_opcode (err_opcode),
        .o_state      (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ALU stand-in ----------------
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] opc);
        logic [7:0] r;
        case (opc)
            6'b100000: r = a + b;
            6'b100010: r = a - b;
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b100111: r = ~(a | b);
            6'b000010: r = a >> b[2:0];
            6'b000011: r = 8'($signed(a) >>> b[2:0]);
            default:   r = 8'h00;
        endcase
        return r;
    endfunction

    assign alu_result = alu_f(op_1, op_2, opcode);

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic ld, input logic ab, input logic [7:0] s);
        reset     = rst;
        btn_load  = ld;
        btn_abort = ab;
        sw        = s;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_st, input logic [7:0] e_op1,
                             input logic [7:0] e_op2, input logic [5:0] e_opc,
                             input logic [7:0] e_res, input logic e_v, input logic e_err);
        check({tag, ".state"},  32'(state),      32'(e_st));
        check({tag, ".op_1"},   32'(op_1),       32'(e_op1));
        check({tag, ".op_2"},   32'(op_2),       32'(e_op2));
        check({tag, ".opcode"}, 32'(opcode),     32'(e_opc));
        check({tag, ".result"}, 32'(result),     32'(e_res));
        check({tag, ".valid"},  32'(valid),      32'(e_v));
        check({tag, ".err"},    32'(err_opcode), 32'(e_err));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       ld;
        logic       ab;
        logic [7:0] sw;
        logic [2:0] st;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [5:0] opc;
        logic [7:0] res;
        logic       v;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic ld, input logic ab, input logic [7:0] s,
                           input logic [2:0] st, input logic [7:0] op1, input logic [7:0] op2,
                           input logic [5:0] opc, input logic [7:0] res,
                           input logic v, input logic err);
        vec_t e;
        e.ld = ld; e.ab = ab; e.sw = s; e.st = st; e.op1 = op1; e.op2 = op2;
        e.opc = opc; e.res = res; e.v = v; e.err = err;
        vecs.push_back(e);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_op1, m_op2, m_res;
    logic [5:0] m_opc;
    logic       m_v, m_err, m_ld_prev, m_ab_prev;
    int         m_stage;
    logic [5:0] legal_ops[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

    function automatic logic legal(input logic [5:0] o);
        foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_op1 = 0; m_op2 = 0; m_opc = 0; m_res = 0;
        m_v = 0; m_err = 0; m_ld_prev = 0; m_ab_prev = 0; m_stage = 0;
    endtask

    // Stage numbers: 0 wait op1, 1 wait op2, 2 wait opcode, 3 executing, 4 result shown.
    task automatic model_step(input logic rst, input logic ld_lvl, input logic ab_lvl,
                              input logic [7:0] s);
        logic press, abort;
        if (rst) begin
            model_reset();
            return;
        end
        press     = ld_lvl && !m_ld_prev;
        abort     = ab_lvl && !m_ab_prev;
        m_ld_prev = ld_lvl;
        m_ab_prev = ab_lvl;
        if (abort) begin
            m_stage = 0; m_v = 0; m_err = 0;
        end else if (m_stage == 3) begin
            m_res = alu_f(m_op1, m_op2, m_opc); m_v = 1; m_stage = 4;
        end else if (press) begin
            if (m_stage == 0 || m_stage == 4) begin
                m_op1 = s; m_v = 0; m_stage = 1;
            end else if (m_stage == 1) begin
                m_op2 = s; m_stage = 2;
            end else if (legal(s[5:0])) begin
                m_opc = s[5:0]; m_err = 0; m_stage = 3;
            end else begin
                m_err = 1;
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        compared   = 0;
        mismatched = 0;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check_all("reset", 3'd0, 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0);

        //      ld ab sw     st op1    op2    opc    res    v  err
        // ADD 1 + 1
        add_vec(1, 0, 8'h01, 1, 8'h01, 8'h00, 6'h00, 8'h00, 0, 0);
        add_vec(0, 0, 8'h01, 1, 8'h01, 8'h00, 6'h00, 8'h00, 0, 0);
        add_vec(1, 0, 8'h01, 2, 8'h01, 8'h01, 6'h00, 8'h00, 0, 0);
        add_vec(0, 0, 8'h01, 2, 8'h01, 8'h01, 6'h00, 8'h00, 0, 0);
        add_vec(1, 0, 8'h20, 3, 8'h01, 8'h01, 6'h20, 8'h00, 0, 0);
        add_vec(0, 0, 8'h20, 4, 8'h01, 8'h01, 6'h20, 8'h02, 1, 0);
        add_vec(0, 0, 8'h20, 4, 8'h01, 8'h01, 6'h20, 8'h02, 1, 0);
        // SUB 4 - 5, reload from S_DONE
        add_vec(1, 0, 8'h04, 1, 8'h04, 8'h01, 6'h20, 8'h02, 0, 0);
        add_vec(0, 0, 8'h04, 1, 8'h04, 8'h01, 6'h20, 8'h02, 0, 0);
        add_vec(1, 0, 8'h05, 2, 8'h04, 8'h05, 6'h20, 8'h02, 0, 0);
        add_vec(0, 0, 8'h05, 2, 8'h04, 8'h05, 6'h20, 8'h02, 0, 0);
        add_vec(1, 0, 8'h22, 3, 8'h04, 8'h05, 6'h22, 8'h02, 0, 0);
        add_vec(0, 0, 8'h22, 4, 8'h04, 8'h05, 6'h22, 8'hFF, 1, 0);
        add_vec(1, 0, 8'hD3, 1, 8'hD3, 8'h05, 6'h22, 8'hFF, 0, 0);
        add_vec(0, 0, 8'hD3, 1, 8'hD3, 8'h05, 6'h22, 8'hFF, 0, 0);
        // Bad opcode then AND
        add_vec(1, 0, 8'h5A, 2, 8'hD3, 8'h5A, 6'h22, 8'hFF, 0, 0);
        add_vec(0, 0, 8'h5A, 2, 8'hD3, 8'h5A, 6'h22, 8'hFF, 0, 0);
        add_vec(1, 0, 8'h3F, 2, 8'hD3, 8'h5A, 6'h22, 8'hFF, 0, 1);
        add_vec(0, 0, 8'h3F, 2, 8'hD3, 8'h5A, 6'h22, 8'hFF, 0, 1);
        add_vec(1, 0, 8'h24, 3, 8'hD3, 8'h5A, 6'h24, 8'hFF, 0, 0);
        add_vec(0, 0, 8'h24, 4, 8'hD3, 8'h5A, 6'h24, 8'h52, 1, 0);
        // Abort in S_DONE, then abort+load in S_OP2
        add_vec(0, 1, 8'h24, 0, 8'hD3, 8'h5A, 6'h24, 8'h52, 0, 0);
        add_vec(1, 0, 8'h11, 1, 8'h11, 8'h5A, 6'h24, 8'h52, 0, 0);
        add_vec(0, 0, 8'h11, 1, 8'h11, 8'h5A, 6'h24, 8'h52, 0, 0);
        add_vec(1, 1, 8'h77, 0, 8'h11, 8'h5A, 6'h24, 8'h52, 0, 0);
        add_vec(0, 0, 8'h77, 0, 8'h11, 8'h5A, 6'h24, 8'h52, 0, 0);
        add_vec(1, 0, 8'h99, 1, 8'h99, 8'h5A, 6'h24, 8'h52, 0, 0);
        // Abort clears a pending opcode error
        add_vec(0, 0, 8'h99, 1, 8'h99, 8'h5A, 6'h24, 8'h52, 0, 0);
        add_vec(1, 0, 8'h33, 2, 8'h99, 8'h33, 6'h24, 8'h52, 0, 0);
        add_vec(0, 0, 8'h33, 2, 8'h99, 8'h33, 6'h24, 8'h52, 0, 0);
        add_vec(1, 0, 8'hFF, 2, 8'h99, 8'h33, 6'h24, 8'h52, 0, 1);
        add_vec(0, 1, 8'hFF, 0, 8'h99, 8'h33, 6'h24, 8'h52, 0, 0);
        add_vec(0, 0, 8'hFF, 0, 8'h99, 8'h33, 6'h24, 8'h52, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b0, vecs[i].ld, vecs[i].ab, vecs[i].sw);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].op1, vecs[i].op2,
                      vecs[i].opc, vecs[i].res, vecs[i].v, vecs[i].err);
        end

        // Held load button: one advance, operand captured once.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 8'hAB);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(i * 7 + 3));
            tick();
            check(.name("held.state"), .act(32'(state)), .exp(32'd1));
            check(.name("held.op_1"),  .act(32'(op_1)),  .exp(32'hAB));
        end

        // Reset while executing: everything zero, no valid pulse afterwards.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 8'h10); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h10); tick();
        drive(1'b0, 1'b1, 1'b0, 8'h20); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h20); tick();
        drive(1'b0, 1'b1, 1'b0, 8'h25); tick();
        check(.name("exec.state"), .act(32'(state)), .exp(32'd3));
        drive(1'b1, 1'b1, 1'b0, 8'h25); tick();
        check_all("rst_exec", 3'd0, 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        check_all("rst_exec2", 3'd0, 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0);

        // Randomized run against the behavioural model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic       r_rst, r_ld, r_ab;
            logic [7:0] r_sw;
            r_rst = ($urandom_range(0, 199) == 0);
            r_ld  = ($urandom_range(0, 1) == 1);
            r_ab  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1)
                r_sw = {2'($urandom_range(0, 3)), legal_ops[$urandom_range(0, 7)]};
            else
                r_sw = 8'($urandom);
            drive(r_rst, r_ld, r_ab, r_sw);
            model_step(r_rst, r_ld, r_ab, r_sw);
            tick();
            check_all($sformatf("rand%0d", i), 3'(m_stage), m_op1, m_op2, m_opc, m_res,
                      m_v, m_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
